// File: rtl/uart_tx_fifo_if.sv
// Host-side bus for the UART transmitter: byte push strobe plus line and FIFO status.
// The host uses the master view and the transmitter uses the slave view.
interface uart_tx_fifo_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       busy;
    logic       full;
    logic       empty;

    modport master (
        output trmt,
        output tx_data,
        input  TX,
        input  tx_done,
        input  busy,
        input  full,
        input  empty
    );

    modport slave (
        input  trmt,
        input  tx_data,
        output TX,
        output tx_done,
        output busy,
        output full,
        output empty
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small FIFO.
// Queued frames are sent back-to-back with no idle gap between them.
module uart_tx_fifo #(
    parameter int BAUD_DIV = 2604,
    parameter int DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic {IDLE, XMIT} state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   baud_reg;
    logic [3:0]      bit_reg;
    logic [9:0]      shift_reg;
    logic            done_reg;
    logic            busy_reg;
    logic [CW-1:0]   cnt_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [7:0]      mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic load;
    logic baud_tick;
    logic frame_end;

    // Flags come from the registered count, so a push is never popped in the same cycle.
    assign full  = (cnt_reg == CNT_FULL);
    assign empty = (cnt_reg == '0);
    assign push  = bus.trmt && !full;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        baud_tick  = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    load       = 1'b1;
                    state_next = XMIT;
                end
            end
            XMIT: begin
                baud_tick = (baud_reg == BAUD_LAST);
                if (baud_tick && (bit_reg == 4'd9)) begin
                    frame_end = 1'b1;
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Shifter LSB drives the line; it refills with ones so the line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '1;
            baud_reg  <= '0;
            bit_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= frame_end;
            busy_reg <= (state_next == XMIT);
            if (load) begin
                shift_reg <= {1'b1, mem[rd_ptr_reg], 1'b0};
                baud_reg  <= '0;
                bit_reg   <= '0;
            end else if (state_reg == XMIT) begin
                if (baud_tick) begin
                    shift_reg <= {1'b1, shift_reg[9:1]};
                    baud_reg  <= '0;
                    bit_reg   <= bit_reg + 4'd1;
                end else begin
                    baud_reg <= baud_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, load})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Storage needs no reset: clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.tx_data;
        end
    end

    assign bus.TX      = shift_reg[0];
    assign bus.tx_done = done_reg;
    assign bus.busy    = busy_reg;
    assign bus.full    = full;
    assign bus.empty   = empty;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter with a small input FIFO. It is the transmit-side counterpart to the segway's UART receiver and shares the same frame format and bit period (2604 clk per bit, 19200 baud at 50 MHz).
- The host side pushes bytes with a single-cycle strobe.
- The block serialises each byte as 1 start bit, 8 data bits LSB first, and 1 stop bit.
- Frames go out back-to-back while the FIFO holds data.

Parameters:
BAUD_DIV, 2604, clk cycles per bit period (must be >= 4)
DEPTH, 4, FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trmt  input  1  push strobe; tx_data is written to the FIFO when trmt=1 and full=0
tx_data  input  8  byte to push
TX  output  1  serial line, idles high
tx_done  output  1  one-cycle pulse at the end of each frame's stop bit
busy  output  1  high while a frame is being shifted (state XMIT)
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries

Behaviour:
- Reset (async, rst_n=0):
  - TX=1, tx_done=0, busy=0, full=0, empty=1, state=IDLE.
  - FIFO pointers, count, baud counter and bit counter all cleared.
- Reset mid-frame aborts the frame immediately. TX goes high and FIFO contents are discarded.
- TX is driven directly from a flop (no glitches). The shifter is 10 bits: {1, data[7:0], 0}. TX is the shifter LSB, and the shifter holds 1 when idle.
- FIFO:
  - Registered count of width $clog2(DEPTH)+1.
  - full and empty are decoded from the registered count.
  - Push when trmt && !full. trmt while full is silently dropped, and FIFO contents are unchanged.
  - Pop is internal, performed by the FSM when loading the shifter.
  - Push and pop in the same cycle: both occur and count is unchanged.
  - A push into an empty FIFO is not popped in the same cycle; it becomes poppable the next cycle.
- FSM states: IDLE, XMIT.
- IDLE:
  - If !empty: pop the head entry, load the shifter, clear the baud counter, clear the bit counter, set busy, go to XMIT.
  - Otherwise stay in IDLE.
- XMIT:
  - The baud counter increments every cycle.
  - When baud counter == BAUD_DIV-1: shift the shifter right, filling with 1. Clear the baud counter and increment the bit counter.
  - When the bit counter reaches 10 on that same edge, the frame is complete:
    - pulse tx_done for exactly 1 cycle;
    - if !empty, pop and load the next frame in the same edge (no idle gap; the next start bit directly follows the stop bit) and stay in XMIT;
    - else go to IDLE and clear busy.
- Latency:
  - A trmt accepted at edge n into an empty FIFO with an idle FSM gives TX=0 after edge n+2 (the push lands at edge n+1 and the FSM loads the shifter at edge n+2).
  - Each bit, including start and stop, is held exactly BAUD_DIV cycles.
  - A frame is exactly 10*BAUD_DIV cycles.
- Capacity: while a frame is in flight, DEPTH further bytes may be queued. With an idle transmitter, up to DEPTH+1 back-to-back pushes are accepted, because the first is popped before the FIFO fills.
- Counter widths:
  - Baud counter: $clog2(BAUD_DIV) bits.
  - Bit counter: 4 bits.
  - No wrap is possible in normal operation.

Test Plan:
1. BAUD_DIV=16, idle; push 0xA5 at cycle 10 -> TX low from cycle 12 for 16 cycles, then bits 1,0,1,0,0,1,0,1 each 16 cycles, then stop 1 for 16 cycles; tx_done high for one cycle at the end of the stop bit; busy high for exactly 160 cycles; empty=1 afterwards.
2. Push 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous 160-cycle frames with no high gap between stop and start; tx_done pulses exactly 160 cycles apart; busy stays high for 480 cycles.
3. DEPTH=4, idle; push 7 bytes 0x01..0x07 on consecutive cycles -> full asserts; 0x01..0x05 are transmitted in order; 0x06 and 0x07 are dropped; exactly 5 tx_done pulses.
4. Push while full coincident with an internal pop at frame end -> the byte is dropped (full was registered high); count goes DEPTH -> DEPTH-1; the next push is accepted.
5. Assert rst_n=0 mid data bit 4 of a frame with 2 bytes queued -> TX=1, busy=0, empty=1 immediately. After release with no push, TX stays high for 1000 cycles and tx_done never pulses.
6. BAUD_DIV=2604; push 0x55 -> each bit period measures 2604 cycles; the frame lasts 26040 cycles; a loopback receiver at the same baud returns 0x55.
